// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer for the pipelined CPU: buffers a program, loads it, pulses reset, runs N cycles, captures result.
// Optional XOR checksum of loaded words is enabled by defining BOOT_CHECKSUM_EN.
module cpu_boot_sequencer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        run_cycles,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_instr,
  input  logic                    in_last,
  input  logic [DATA_W-1:0]       cpu_out,
  output logic                    cpu_load,
  output logic [DATA_W-1:0]       cpu_instr,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       result,
  output logic [$clog2(DEPTH):0]  loaded_cnt,
  output logic                    overflow
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]       checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_POST_RST,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                in_ready_nxt;
  logic                cpu_load_nxt;
  logic [DATA_W-1:0]   cpu_instr_nxt;
  logic                cpu_reset_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic [DATA_W-1:0]   result_nxt;
  logic [CW-1:0]       loaded_nxt;
  logic                overflow_nxt;
  logic [CW-1:0]       rd_idx, rd_idx_nxt;
  logic [CNT_W-1:0]    run_len, run_len_nxt;
  logic [CNT_W-1:0]    run_cnt, run_cnt_nxt;
  logic                wr_en;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_nxt;
`endif

  assign wr_en = (state == S_FILL) && in_ready && in_valid;

  // Program buffer is deliberately not reset; stale words are never read back.
  always_ff @(posedge clk) begin
    if (wr_en) mem[loaded_cnt[AW-1:0]] <= in_instr;
  end

  always_comb begin
    state_nxt     = state;
    in_ready_nxt  = in_ready;
    cpu_load_nxt  = cpu_load;
    cpu_instr_nxt = cpu_instr;
    cpu_reset_nxt = cpu_reset;
    busy_nxt      = busy;
    done_nxt      = done;
    result_nxt    = result;
    loaded_nxt    = loaded_cnt;
    overflow_nxt  = overflow;
    rd_idx_nxt    = rd_idx;
    run_len_nxt   = run_len;
    run_cnt_nxt   = run_cnt;
`ifdef BOOT_CHECKSUM_EN
    checksum_nxt  = checksum;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt     = S_FILL;
          in_ready_nxt  = 1'b1;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          overflow_nxt  = 1'b0;
          loaded_nxt    = '0;
          run_len_nxt   = run_cycles;
          cpu_reset_nxt = 1'b1;
`ifdef BOOT_CHECKSUM_EN
          checksum_nxt  = '0;
`endif
        end
      end

      S_FILL: begin
        if (wr_en) begin
          loaded_nxt = loaded_cnt + CW'(1);
          if (in_last || (loaded_nxt == FULL)) begin
            state_nxt     = S_LOAD;
            in_ready_nxt  = 1'b0;
            overflow_nxt  = !in_last;
            cpu_load_nxt  = 1'b1;
            cpu_reset_nxt = 1'b0;
            // A one-word program is still being written, so forward it directly.
            cpu_instr_nxt = (loaded_cnt == '0) ? in_instr : mem[0];
            rd_idx_nxt    = CW'(1);
          end
        end
      end

      S_LOAD: begin
        if (rd_idx == loaded_cnt) begin
          state_nxt     = S_POST_RST;
          cpu_load_nxt  = 1'b0;
          cpu_instr_nxt = '0;
          cpu_reset_nxt = 1'b1;
        end else begin
          cpu_instr_nxt = mem[rd_idx[AW-1:0]];
          rd_idx_nxt    = rd_idx + CW'(1);
        end
      end

      S_POST_RST: begin
        if (run_len != '0) begin
          state_nxt     = S_RUN;
          cpu_reset_nxt = 1'b0;
          run_cnt_nxt   = run_len;
        end else begin
          state_nxt  = S_DONE;
          result_nxt = cpu_out;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
        end
      end

      S_RUN: begin
        if (run_cnt <= CNT_W'(1)) begin
          state_nxt     = S_DONE;
          result_nxt    = cpu_out;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          cpu_reset_nxt = 1'b1;
        end else begin
          run_cnt_nxt = run_cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        in_ready_nxt  = 1'b0;
        cpu_load_nxt  = 1'b0;
        cpu_instr_nxt = '0;
        cpu_reset_nxt = 1'b1;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
      end
    endcase

`ifdef BOOT_CHECKSUM_EN
    if (cpu_load_nxt) checksum_nxt = checksum ^ cpu_instr_nxt;
`endif
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      cpu_load   <= 1'b0;
      cpu_instr  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      loaded_cnt <= '0;
      overflow   <= 1'b0;
      rd_idx     <= '0;
      run_len    <= '0;
      run_cnt    <= '0;
`ifdef BOOT_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      in_ready   <= in_ready_nxt;
      cpu_load   <= cpu_load_nxt;
      cpu_instr  <= cpu_instr_nxt;
      cpu_reset  <= cpu_reset_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      result     <= result_nxt;
      loaded_cnt <= loaded_nxt;
      overflow   <= overflow_nxt;
      rd_idx     <= rd_idx_nxt;
      run_len    <= run_len_nxt;
      run_cnt    <= run_cnt_nxt;
`ifdef BOOT_CHECKSUM_EN
      checksum   <= checksum_nxt;
`endif
    end
  end

endmodule
